// File: rtl/comp_dac_load_seq_tmr_pkg.sv
// Shared constants for the comparator-threshold DAC load sequencer.
package comp_dac_load_seq_tmr_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PLOAD    = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_LATCH    = 3'd3;
  localparam logic [2:0] ST_SET_DONE = 3'd4;

  // Width of the bits-remaining counter; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned nbits);
    return (nbits > 32'd1) ? unsigned'($clog2(nbits)) : 32'd1;
  endfunction

  // Width of the active-channel index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned nchan);
    return (nchan > 32'd1) ? unsigned'($clog2(nchan)) : 32'd1;
  endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter with replica disagreement flag.
module tmr_vote #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] vote_c,
  output logic         err_c
);

  // Majority per bit; any differing bit raises the flag.
  always_comb begin
    vote_c = (a & b) | (a & c) | (b & c);
    err_c  = |((a ^ b) | (a ^ c));
  end

endmodule

// File: rtl/comp_dac_load_seq_tmr.sv
// Serial load sequencer for comparator-threshold DACs, optionally triplicated.
module comp_dac_load_seq_tmr
  import comp_dac_load_seq_tmr_pkg::*;
#(
  parameter int unsigned NBITS = 16,
  parameter int unsigned NCHAN = 7,
  parameter int unsigned TMR   = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic [NCHAN-1:0]         CHAN_MASK,
  output logic                     SHFT_ENA,
  output logic [NCHAN-1:0]         CHAN_SEL,
  output logic                     LOAD,
  output logic [cnt_w(NBITS)-1:0]  BIT_CNT,
  output logic                     BUSY,
  output logic                     SET_DONE,
  output logic                     TMR_ERR
);

  localparam int unsigned CW = cnt_w(NBITS);
  localparam int unsigned IW = idx_w(NCHAN);
  localparam int unsigned DW = CW + IW + NCHAN;

  // Voted (or single-copy) current values.
  logic [ST_W-1:0]  st_v;
  logic [CW-1:0]    cnt_v;
  logic [IW-1:0]    idx_v;
  logic [NCHAN-1:0] msk_v;
  logic [DW-1:0]    dat_v;

  // Next values shared by every replica.
  logic [ST_W-1:0]  nxt_st;
  logic [CW-1:0]    nxt_cnt;
  logic [IW-1:0]    nxt_idx;
  logic [NCHAN-1:0] nxt_msk;
  logic [DW-1:0]    nxt_dat;
  logic             nxt_busy_c;
  logic             mis_c;

  assign {cnt_v, idx_v, msk_v} = dat_v;
  assign nxt_dat = {nxt_cnt, nxt_idx, nxt_msk};
  assign nxt_busy_c = (nxt_st == ST_PLOAD) || (nxt_st == ST_SHIFT) || (nxt_st == ST_LATCH);

  // Lowest-indexed set bit of a channel mask.
  function automatic logic [IW-1:0] lowest(input logic [NCHAN-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (m[i]) r = IW'(i);
    end
    return r;
  endfunction

  // Next-state logic; entering Pload picks the next channel and consumes its mask bit.
  always_comb begin
    logic [NCHAN-1:0] pick_msk;
    logic             pick;
    nxt_st   = st_v;
    nxt_cnt  = cnt_v;
    nxt_idx  = idx_v;
    nxt_msk  = msk_v;
    pick_msk = msk_v;
    pick     = 1'b0;
    case (st_v)
      ST_IDLE: begin
        if (START) begin
          pick_msk = CHAN_MASK;
          nxt_msk  = CHAN_MASK;
          if (|CHAN_MASK) begin
            nxt_st = ST_PLOAD;
            pick   = 1'b1;
          end else begin
            nxt_st = ST_SET_DONE;
          end
        end
      end
      ST_PLOAD: nxt_st = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_v == '0) nxt_st = ST_LATCH;
        else             nxt_cnt = cnt_v - CW'(1);
      end
      ST_LATCH: begin
        if (|msk_v) begin
          nxt_st = ST_PLOAD;
          pick   = 1'b1;
        end else begin
          nxt_st  = ST_SET_DONE;
          nxt_cnt = '0;
        end
      end
      ST_SET_DONE: begin
        if (!START) nxt_st = ST_IDLE;
      end
      default: begin
        nxt_st  = ST_IDLE;
        nxt_cnt = '0;
        nxt_idx = '0;
        nxt_msk = '0;
      end
    endcase
    if (pick) begin
      nxt_idx = lowest(pick_msk);
      nxt_msk = pick_msk & ~(NCHAN'(1) << nxt_idx);
      nxt_cnt = CW'(NBITS - 1);
    end
  end

  if (TMR != 0) begin : gen_tmr
    logic [ST_W-1:0] st_q0, st_q1, st_q2;
    logic [DW-1:0]   dat_q0, dat_q1, dat_q2;
    logic            st_err_c, dat_err_c;

    // Three replicas all load the next value derived from the voted state.
    always_ff @(negedge CLK) begin
      if (!RST_N) begin
        st_q0  <= ST_IDLE;
        st_q1  <= ST_IDLE;
        st_q2  <= ST_IDLE;
        dat_q0 <= '0;
        dat_q1 <= '0;
        dat_q2 <= '0;
      end else begin
        st_q0  <= nxt_st;
        st_q1  <= nxt_st;
        st_q2  <= nxt_st;
        dat_q0 <= nxt_dat;
        dat_q1 <= nxt_dat;
        dat_q2 <= nxt_dat;
      end
    end

    tmr_vote #(.W(ST_W)) u_vote_st (
      .a(st_q0), .b(st_q1), .c(st_q2), .vote_c(st_v), .err_c(st_err_c)
    );

    tmr_vote #(.W(DW)) u_vote_dat (
      .a(dat_q0), .b(dat_q1), .c(dat_q2), .vote_c(dat_v), .err_c(dat_err_c)
    );

    assign mis_c = st_err_c | dat_err_c;
  end else begin : gen_single
    logic [ST_W-1:0] st_q;
    logic [DW-1:0]   dat_q;

    // Single-copy state register.
    always_ff @(negedge CLK) begin
      if (!RST_N) begin
        st_q  <= ST_IDLE;
        dat_q <= '0;
      end else begin
        st_q  <= nxt_st;
        dat_q <= nxt_dat;
      end
    end

    assign st_v  = st_q;
    assign dat_v = dat_q;
    assign mis_c = 1'b0;
  end

  // Outputs registered from the next state so they align with the state they describe.
  always_ff @(negedge CLK) begin
    if (!RST_N) begin
      SHFT_ENA <= 1'b0;
      CHAN_SEL <= '0;
      LOAD     <= 1'b0;
      BIT_CNT  <= '0;
      BUSY     <= 1'b0;
      SET_DONE <= 1'b0;
      TMR_ERR  <= 1'b0;
    end else begin
      SHFT_ENA <= (nxt_st == ST_SHIFT);
      CHAN_SEL <= nxt_busy_c ? (NCHAN'(1) << nxt_idx) : '0;
      LOAD     <= (nxt_st == ST_LATCH);
      BIT_CNT  <= nxt_cnt;
      BUSY     <= nxt_busy_c;
      SET_DONE <= (nxt_st == ST_SET_DONE);
      TMR_ERR  <= TMR_ERR | mis_c;
    end
  end

endmodule

// File: tb/tb_comp_dac_load_seq_tmr.sv
// Directed bench for the DAC load sequencer: vector table plus reset, fault and small-config cases.
module tb_comp_dac_load_seq_tmr;
  import comp_dac_load_seq_tmr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] chan_mask;
  logic       shft_ena, load, busy, set_done, tmr_err;
  logic [6:0] chan_sel;
  logic [3:0] bit_cnt;

  logic       start2;
  logic [0:0] mask2;
  logic       shft2, load2, busy2, done2, err2;
  logic [0:0] sel2;
  logic [0:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ld;

  typedef struct {
    logic [6:0] mask;
    bit         drop;
    int         inject;
    int         loads;
    int         shifts;
    int         done_edge;
    logic [6:0] first_sel;
    logic [6:0] last_sel;
    logic [3:0] cnt1;
    logic       busy1;
    logic       err;
  } vec_t;

  vec_t       vecs[7];
  logic [6:0] exp2[6];

  always #5 clk = ~clk;

  comp_dac_load_seq_tmr #(.NBITS(16), .NCHAN(7), .TMR(1)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .CHAN_MASK(chan_mask),
    .SHFT_ENA(shft_ena), .CHAN_SEL(chan_sel), .LOAD(load), .BIT_CNT(bit_cnt),
    .BUSY(busy), .SET_DONE(set_done), .TMR_ERR(tmr_err)
  );

  comp_dac_load_seq_tmr #(.NBITS(2), .NCHAN(1), .TMR(0)) dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .CHAN_MASK(mask2),
    .SHFT_ENA(shft2), .CHAN_SEL(sel2), .LOAD(load2), .BIT_CNT(cnt2),
    .BUSY(busy2), .SET_DONE(done2), .TMR_ERR(err2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic run_seq(input vec_t v, input string tag);
    int         loads, shifts, done_edge, viol;
    logic [6:0] first_sel, last_sel, prev_sel;
    logic       prev_load;
    loads = 0; shifts = 0; done_edge = 0; viol = 0;
    first_sel = '0; last_sel = '0; prev_sel = '0; prev_load = 1'b0;
    start = 1'b1;
    chan_mask = v.mask;
    for (int e = 1; e <= 400; e++) begin
      step();
      if (e == 1) begin
        chk({tag, ".busy_e1"}, 64'(busy), 64'(v.busy1));
        chk({tag, ".bitcnt_e1"}, 64'(bit_cnt), 64'(v.cnt1));
        chan_mask = ~v.mask;
      end
      if (e == 2 && v.drop) start = 1'b0;
      if (load) begin
        loads++;
        if (loads == 1) first_sel = chan_sel;
        last_sel = chan_sel;
      end
      if (shft_ena) shifts++;
      if (busy && !$onehot(chan_sel)) viol++;
      if (!busy && (shft_ena || load || chan_sel != '0)) viol++;
      if (busy && prev_sel != '0 && !prev_load && chan_sel != prev_sel) viol++;
      if (shft_ena && load) viol++;
      prev_sel  = chan_sel;
      prev_load = load;
      if (v.inject != 0 && e == v.inject) force dut.gen_tmr.st_q1 = ST_SET_DONE;
      if (v.inject != 0 && e == v.inject + 1) release dut.gen_tmr.st_q1;
      if (set_done) begin
        done_edge = e;
        break;
      end
    end
    chk({tag, ".done_edge"}, 64'(done_edge), 64'(v.done_edge));
    chk({tag, ".loads"}, 64'(loads), 64'(v.loads));
    chk({tag, ".shifts"}, 64'(shifts), 64'(v.shifts));
    chk({tag, ".first_sel"}, 64'(first_sel), 64'(v.first_sel));
    chk({tag, ".last_sel"}, 64'(last_sel), 64'(v.last_sel));
    chk({tag, ".protocol"}, 64'(viol), 64'd0);
    if (!v.drop) begin
      step();
      chk({tag, ".done_hold"}, 64'(set_done), 64'd1);
    end
    start = 1'b0;
    step();
    chk({tag, ".idle"}, 64'({busy, set_done, shft_ena, load, chan_sel, bit_cnt}), 64'd0);
    chk({tag, ".tmr_err"}, 64'(tmr_err), 64'(v.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{7'h7F, 1'b0, 0, 7, 112, 127, 7'h01, 7'h40, 4'd15, 1'b1, 1'b0};
    vecs[1] = '{7'h24, 1'b0, 0, 2,  32,  37, 7'h04, 7'h20, 4'd15, 1'b1, 1'b0};
    vecs[2] = '{7'h00, 1'b0, 0, 0,   0,   1, 7'h00, 7'h00, 4'd0,  1'b0, 1'b0};
    vecs[3] = '{7'h40, 1'b1, 0, 1,  16,  19, 7'h40, 7'h40, 4'd15, 1'b1, 1'b0};
    vecs[4] = '{7'h03, 1'b0, 0, 2,  32,  37, 7'h01, 7'h02, 4'd15, 1'b1, 1'b0};
    vecs[5] = '{7'h55, 1'b1, 0, 4,  64,  73, 7'h01, 7'h40, 4'd15, 1'b1, 1'b0};
    vecs[6] = '{7'h24, 1'b0, 5, 2,  32,  37, 7'h04, 7'h20, 4'd15, 1'b1, 1'b1};

    // {shft, load, busy, done, cnt, sel, err} per edge for NBITS=2, NCHAN=1
    exp2[0] = 7'b0010110;
    exp2[1] = 7'b1010110;
    exp2[2] = 7'b1010010;
    exp2[3] = 7'b0110010;
    exp2[4] = 7'b0001000;
    exp2[5] = 7'b0000000;

    rst_n = 1'b0; start = 1'b0; chan_mask = '0; start2 = 1'b0; mask2 = '0;
    repeat (3) step();
    chk("reset.outs", 64'({shft_ena, load, busy, set_done, tmr_err, chan_sel, bit_cnt}), 64'd0);
    chk("reset.outs2", 64'({shft2, load2, busy2, done2, err2, sel2, cnt2}), 64'd0);
    rst_n = 1'b1;
    step();
    chk("reset.idle_hold", 64'({busy, set_done}), 64'd0);

    for (int i = 0; i < 7; i++) run_seq(vecs[i], $sformatf("vec%0d", i));

    // Fault flag is sticky and only reset clears it.
    step();
    chk("tmr.sticky", 64'(tmr_err), 64'd1);
    rst_n = 1'b0;
    step();
    chk("tmr.reset_clear", 64'(tmr_err), 64'd0);
    rst_n = 1'b1;
    step();

    // Reset during channel 3 shift, START held, then full restart.
    n_ld = 0;
    start = 1'b1;
    chan_mask = 7'h7F;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (load) n_ld++;
    end
    chk("midrst.sel_ch3", 64'(chan_sel), 64'h08);
    chk("midrst.shifting", 64'(shft_ena), 64'd1);
    chk("midrst.loads_before", 64'(n_ld), 64'd3);
    rst_n = 1'b0;
    step();
    chk("midrst.outs", 64'({shft_ena, load, busy, set_done, tmr_err, chan_sel, bit_cnt}), 64'd0);
    rst_n = 1'b1;
    run_seq(vecs[0], "restart");

    // Minimal configuration walked edge by edge.
    start2 = 1'b1;
    mask2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("small.e%0d", i + 1), 64'({shft2, load2, busy2, done2, cnt2, sel2, err2}),
          64'(exp2[i]));
      if (i == 4) start2 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
